// File: rtl/clock_bcd_display.sv
// Display back-end: snapshots {hour,min,sec} and converts each field to BCD with a
// sequential shift-add-3 engine. Drives a six-digit multiplexed seven-segment display.
module clock_bcd_display #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sec,
  input  logic [7:0] min,
  input  logic [7:0] hour,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       dp,
  output logic       busy
);

  localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_t;

  state_t          state, state_nxt;
  logic [23:0]     snap;
  logic [1:0]      fld;
  logic [2:0]      bcnt;
  logic [11:0]     bcd;
  logic [3:0]      stg [6];
  logic [3:0]      d   [6];
  logic [PW-1:0]   presc;
  logic [2:0]      idx;

  logic            load_c, step_c, commit_c;
  logic [7:0]      field_val_c;
  logic            field_bit_c;
  logic [11:0]     bcd_adj_c;
  logic [11:0]     bcd_shf_c;
  logic            last_bit_c;
  logic            sat_c;
  logic [2:0]      stg_lo_c, stg_hi_c;

  // Active-low gfedcba code for one BCD digit; anything else blanks the digit.
  function automatic logic [6:0] seg_code(input logic [3:0] v);
    case (v)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  // One double-dabble step on the scratch: add 3 to nibbles >= 5, then shift in the field MSB.
  always_comb begin
    case (fld)
      2'd0:    field_val_c = snap[7:0];
      2'd1:    field_val_c = snap[15:8];
      default: field_val_c = snap[23:16];
    endcase
    field_bit_c = field_val_c[3'd7 - bcnt];
    for (int i = 0; i < 3; i++) begin
      bcd_adj_c[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? 4'(bcd[i*4 +: 4] + 4'd3) : bcd[i*4 +: 4];
    end
    bcd_shf_c  = 12'({bcd_adj_c, field_bit_c});
    last_bit_c = (bcnt == 3'd7);
    sat_c      = (bcd_shf_c[11:8] != 4'd0);
    stg_lo_c   = {fld, 1'b0};
    stg_hi_c   = {fld, 1'b1};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and control strobes.
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    step_c    = 1'b0;
    commit_c  = 1'b0;
    case (state)
      IDLE: begin
        if ({hour, min, sec} != snap) begin
          load_c    = 1'b1;
          state_nxt = CONV;
        end
      end
      CONV: begin
        step_c = 1'b1;
        if (last_bit_c && (fld == 2'd2)) state_nxt = COMMIT;
      end
      COMMIT: begin
        commit_c  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Conversion datapath: snapshot, scratch, staging and display registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap <= '0;
      fld  <= '0;
      bcnt <= '0;
      bcd  <= '0;
      busy <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        stg[i] <= '0;
        d[i]   <= '0;
      end
    end else begin
      busy <= (state_nxt != IDLE);
      if (load_c) begin
        snap <= {hour, min, sec};
        fld  <= '0;
        bcnt <= '0;
        bcd  <= '0;
      end
      if (step_c) begin
        bcnt <= 3'(bcnt + 3'd1);
        if (last_bit_c) begin
          bcd           <= '0;
          fld           <= 2'(fld + 2'd1);
          stg[stg_lo_c] <= sat_c ? 4'd9 : bcd_shf_c[3:0];
          stg[stg_hi_c] <= sat_c ? 4'd9 : bcd_shf_c[7:4];
        end else begin
          bcd <= bcd_shf_c;
        end
      end
      if (commit_c) begin
        for (int i = 0; i < 6; i++) d[i] <= stg[i];
      end
    end
  end

  // Scan prescaler, digit index and registered display drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
      an    <= 6'b111110;
      seg   <= 7'b1000000;
      dp    <= 1'b1;
    end else begin
      if (presc == PW'(SCAN_DIV - 1)) begin
        presc <= '0;
        idx   <= (idx == 3'd5) ? 3'd0 : 3'(idx + 3'd1);
      end else begin
        presc <= PW'(presc + PW'(1));
      end
      an  <= ~(6'd1 << idx);
      seg <= seg_code(d[idx]);
      dp  <= ~((idx == 3'd2) || (idx == 3'd4));
    end
  end

endmodule

// File: tb/tb_clock_bcd_display.sv
// Scoreboard bench for clock_bcd_display: a spec-level model predicts busy and the
// committed digits; a monitor checks every committed value through the scanned display.
module tb_clock_bcd_display;

  localparam int unsigned SD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sec, min, hour;
  logic [6:0] seg;
  logic [5:0] an;
  logic       dp, busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [23:0] expq[$];
  logic [23:0] m_snap;
  int          m_cnt = 0;
  bit          mon_active = 1'b0;
  logic [6:0]  segtab [16];

  always #5 clk = ~clk;

  clock_bcd_display #(.SCAN_DIV(SD)) dut (
    .clk  (clk),
    .rst  (rst),
    .sec  (sec),
    .min  (min),
    .hour (hour),
    .seg  (seg),
    .an   (an),
    .dp   (dp),
    .busy (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected digits d5..d4..d0 packed as nibbles; fields above 99 show 9,9.
  function automatic logic [23:0] model_digits(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
    logic [23:0] r;
    int v[3];
    v[0] = int'(s); v[1] = int'(m); v[2] = int'(h);
    r = '0;
    for (int f = 0; f < 3; f++) begin
      if (v[f] > 99) begin
        r[f*8 +: 4]     = 4'd9;
        r[f*8 + 4 +: 4] = 4'd9;
      end else begin
        r[f*8 +: 4]     = 4'(v[f] % 10);
        r[f*8 + 4 +: 4] = 4'(v[f] / 10);
      end
    end
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) segtab[i] = 7'b1111111;
    segtab[0] = 7'b1000000; segtab[1] = 7'b1111001; segtab[2] = 7'b0100100;
    segtab[3] = 7'b0110000; segtab[4] = 7'b0011001; segtab[5] = 7'b0010010;
    segtab[6] = 7'b0000010; segtab[7] = 7'b1111000; segtab[8] = 7'b0000000;
    segtab[9] = 7'b0010000;
  end

  // Reference model: a changed input seen while idle starts a 25-cycle busy period.
  always @(posedge clk) begin
    if (rst) begin
      m_snap = '0;
      m_cnt  = 0;
      expq.delete();
    end else if (m_cnt == 0) begin
      if ({hour, min, sec} != m_snap) begin
        m_snap = {hour, min, sec};
        expq.push_back(model_digits(sec, min, hour));
        m_cnt = 25;
      end
    end else begin
      m_cnt--;
    end
    #1;
    check("busy", 32'(busy), 32'(m_cnt != 0));
  end

  // Monitor: on each commit, pop the expected digits and check 24 cycles of scan output.
  initial begin
    logic        prev_busy;
    logic [23:0] e;
    logic [5:0]  onehot;
    int          id, cur, run;
    bit          first;
    prev_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst && prev_busy && !busy) begin
        mon_active = 1'b1;
        if (expq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL commit: unexpected commit, none was expected (t=%0t)", $time);
        end else begin
          e     = expq.pop_front();
          cur   = -1;
          run   = 0;
          first = 1'b1;
          for (int k = 0; k < 6 * SD; k++) begin
            @(posedge clk); #1;
            id = -1;
            for (int i = 0; i < 6; i++) begin
              onehot = 6'd1 << i;
              if (an == ~onehot) id = i;
            end
            check("an_onehot", 32'(id >= 0), 32'd1);
            if (id >= 0) begin
              check("seg", 32'(seg), 32'(segtab[e[id*4 +: 4]]));
              check("dp", 32'(dp), 32'((id == 2 || id == 4) ? 1'b0 : 1'b1));
              if (cur < 0) begin
                cur = id; run = 1;
              end else if (id == cur) begin
                run++;
                if (run > int'(SD)) check("scan_run_max", 32'(run), 32'(SD));
              end else begin
                check("scan_next", 32'(id), 32'((cur + 1) % 6));
                if (!first) check("scan_run", 32'(run), 32'(SD));
                first = 1'b0;
                cur = id; run = 1;
              end
            end
          end
        end
        mon_active = 1'b0;
      end
      prev_busy = busy;
    end
  end

  task automatic set_in(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
    @(negedge clk);
    sec = s; min = m; hour = h;
  endtask

  task automatic wait_quiet(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy && m_cnt == 0 && expq.size() == 0 && !mon_active) return;
    end
    n_cmp++; n_err++;
    $display("FAIL wait_quiet: design still busy after %0d cycles", budget);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"},   32'(an),   32'(6'b111110));
    check({tag, "_seg"},  32'(seg),  32'(7'b1000000));
    check({tag, "_dp"},   32'(dp),   32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst  = 1'b1;
    sec  = 8'($urandom_range(1, 255));
    min  = 8'($urandom_range(1, 255));
    hour = 8'($urandom_range(1, 255));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");
    wait_quiet(300);

    set_in(8'd45, 8'd7, 8'd13);
    wait_quiet(300);

    set_in(8'd200, 8'd99, 8'd100);
    wait_quiet(300);

    for (int n = 0; n < 8; n++) begin
      if (n % 2 == 0) set_in(8'($urandom_range(0, 59)), 8'($urandom_range(0, 59)), 8'($urandom_range(0, 23)));
      else            set_in(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      wait_quiet(300);
    end

    set_in(sec, min, hour);
    repeat (6) @(negedge clk);

    set_in(8'd12, 8'd34, 8'd56);
    repeat (10) @(negedge clk);
    sec = 8'd21;
    wait_quiet(400);

    set_in(8'd9, 8'd8, 8'd7);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midreset");
    wait_quiet(300);

    check("queue_empty", 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/clock_bcd_display.md
# clock_bcd_display

Display back-end for the digital clock counters. Samples the binary `sec`, `min` and `hour` bytes and converts each to two BCD digits with a sequential shift-add-3 engine. Drives a six-digit, common-anode, time-multiplexed seven-segment display with active-low segments and anodes. Sits directly downstream of the clock counter block and is the last stage before the board pins.

## Interface
- `SCAN_DIV`, default 1000: clk cycles each digit stays lit; legal range ≥ 2.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `sec`  in  8  binary seconds value from the counter stage.
- `min`  in  8  binary minutes value from the counter stage.
- `hour`  in  8  binary hours value from the counter stage.
- `seg`  out  7  segment drive, bit order {g,f,e,d,c,b,a}, active-low.
- `an`  out  6  digit anodes, one-hot active-low; `an[0]` is seconds ones, `an[5]` is hours tens.
- `dp`  out  1  decimal point, active-low.
- `busy`  out  1  high while a conversion is in progress.

## Operation
- Snapshot register `snap[23:0]` holds {hour,min,sec}. Display registers hold six 4-bit digits `d0..d5`.
- FSM states and transitions:
  - IDLE: if {hour,min,sec} != `snap`, load `snap` with the inputs, clear field index and bit counter, then go to CONV. Otherwise stay in IDLE.
  - CONV: one double-dabble step per cycle on a 12-bit BCD scratch for the current field.
    - Each step adds 3 to any nibble ≥ 5, then shifts in the field's next MSB.
    - 8 steps per field, fields processed in order sec, min, hour: 24 cycles total.
    - Each field's BCD result goes to a staging register.
  - COMMIT: copy all staging digits into `d0..d5` in the same cycle, then go to IDLE.
- Saturation: if a field's hundreds nibble is non-zero (value > 99), its staged digits are 9,9.
- Inputs are ignored outside IDLE. A change during CONV/COMMIT is picked up at the first IDLE compare.
- `busy` = 1 in CONV and COMMIT, 0 in IDLE.
- Scan logic:
  - Prescaler counts 0..SCAN_DIV-1.
  - On wrap, digit index advances 0→1→…→5→0.
- `an`, `seg` and `dp` are registered decodes of the current index and `d[index]`.
- `dp` is 0 (lit) only when the index is 2 or 4 (separators after sec and min).
- Segment codes, active-low gfedcba:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Any other code = 1111111 (blank).

## Timing
- Reset values (register state):
  - state = IDLE, `snap` = 0, `d0..d5` = 0, prescaler = 0, index = 0.
- Reset values (outputs):
  - `an` = 111110, `seg` = 1000000, `dp` = 1, `busy` = 0.
- Reset has priority over every other action. Reset during CONV abandons the conversion; display registers return to 0.
- Conversion latency, where N is the edge at which IDLE samples the mismatch:
  - Edges N+1..N+24 perform the shifts.
  - COMMIT updates `d0..d5` at edge N+25.
  - Earliest next IDLE compare is edge N+26.
- `busy` rises after edge N and falls after edge N+25.
- Scan timing:
  - Index changes at every SCAN_DIV-th edge.
  - `an`/`seg`/`dp` follow one cycle later.
  - A full refresh takes 6·SCAN_DIV cycles.
- A display-register update mid-scan takes effect on the next output register update. There is no tearing within a digit.

## Test plan
- Reset: hold `rst` 3 cycles with random inputs.
  - Required: `an` = 111110, `seg` = 1000000, `dp` = 1, `busy` = 0 on the cycle after release.
- Conversion: `sec` = 45, `min` = 7, `hour` = 13 from an idle state.
  - Required: `busy` high for exactly 25 cycles.
  - Required after: `d0..d5` = 5,4,7,0,3,1.
- Saturation: `sec` = 200, `min` = 99, `hour` = 100.
  - Required: digits 9,9,9,9,9,9.
  - Required: `seg` = 0010000 on every digit.
- Scan (SCAN_DIV = 4, digits 5,4,7,0,3,1):
  - Required: `an` walks 111110, 111101, …, 011111, changing every 4 cycles.
  - Required: `seg` matches each digit.
  - Required: `dp` = 0 only while `an` = 111011 or 101111.
- Mid-conversion change: change `sec` 10 cycles into CONV.
  - Required: first commit shows the old value.
  - Required: a second conversion starts at the first IDLE compare and commits the new value 25 cycles later.
- Mid-conversion reset: assert `rst` during CONV.
  - Required: outputs return to reset values.
  - Required: with non-zero inputs, a fresh conversion starts on the first IDLE cycle after release.
